mayor_serie: RTL

Sequential magnitude comparator for two unsigned WIDTH-bit operands that arrive as 2-bit digit pairs, most-significant digit first, one pair per accepted cycle. Each pair gets a 2-bit greater/equal/less evaluation. The first unequal pair fixes the result. After the last digit the block raises a one-cycle done pulse and holds registered gt/eq/lt flags. It sits downstream of the digit-serial datapath and reports the final relation to the control logic.

---
 rtl/mayor_serie_if.sv | 24 ++
 rtl/mayor_serie.sv | 102 ++++++++++
 2 files changed

// File: rtl/mayor_serie_if.sv
// Digit-pair bus of the serial magnitude comparator.
// The master drives start and the digits. The slave (the comparator) returns
// its status and the registered relation flags.
interface mayor_serie_if;
  logic       start;
  logic       dig_valid;
  logic [1:0] a_dig;
  logic [1:0] b_dig;
  logic       busy;
  logic       done;
  logic       gt;
  logic       eq;
  logic       lt;

  modport master (
    output start, dig_valid, a_dig, b_dig,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, dig_valid, a_dig, b_dig,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/mayor_serie.sv
// Digit-serial unsigned magnitude comparator.
// Operands arrive as 2-bit digit pairs, most-significant digit first.
// The first unequal pair decides the relation. After the last pair, done
// pulses for one cycle and the registered gt/eq/lt flags are updated.
module mayor_serie #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mayor_serie_if.slave  bus
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(DIGITS) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_GT = 2'b01;
  localparam logic [1:0] REL_LT = 2'b10;

  // Local relation of a single digit pair
  function automatic logic [1:0] f_dig_rel(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = REL_EQ;
    if (a > b)      r = REL_GT;
    else if (a < b) r = REL_LT;
    return r;
  endfunction

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rel;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic             w_consume;
  logic             w_last;
  logic [1:0]       w_rel_nxt;

  // A pair is taken only in RUN. Once rel is decided, later digits are ignored.
  always_comb begin
    w_consume = (r_state == S_RUN) && bus.dig_valid;
    w_last    = w_consume && (r_cnt == CNT_W'(DIGITS - 1));
    w_rel_nxt = (r_rel == REL_EQ) ? f_dig_rel(bus.a_dig, bus.b_dig) : r_rel;
  end

  // Control FSM, digit counter, relation and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rel   <= REL_EQ;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_rel   <= REL_EQ;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_consume) begin
            r_rel <= w_rel_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_gt    <= (w_rel_nxt == REL_GT);
              r_eq    <= (w_rel_nxt == REL_EQ);
              r_lt    <= (w_rel_nxt == REL_LT);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;

endmodule
